// File: rtl/vblank_dma.sv
// vblank_dma: vsync-triggered multi-channel block-copy engine.
// Each vsync rising edge walks channels 0..CHANNELS-1 and copies LEN bytes per
// enabled channel from SRC to DST over the shared 16-bit/8-bit master bus.
// Bus outputs, busy and done are registered; dout is combinational from cs/addr.
module vblank_dma #(
  parameter int CHANNELS = 4,
  parameter int RA       = $clog2(CHANNELS) + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          cs,
  input  logic          rw,
  input  logic [RA-1:0] addr,
  input  logic [7:0]    di,
  output logic [7:0]    dout,
  output logic [15:0]   m_addr,
  output logic [7:0]    m_do,
  input  logic [7:0]    m_di,
  output logic          m_rw,
  output logic          busy,
  output logic          done
);

  // Channel-slot index width, number of register slots, and pass counter width
  // (the counter must also hold the value CHANNELS, which ends a pass).
  localparam int CIW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NSLOT = 1 << CIW;
  localparam int CHW   = $clog2(CHANNELS + 1);
  localparam logic [CHW-1:0] CH_END = CHW'(CHANNELS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_NEXT = 3'd5
  } state_t;

  // Programmed per-channel configuration.
  logic [15:0] src_q  [NSLOT];
  logic [15:0] dst_q  [NSLOT];
  logic [7:0]  len_q  [NSLOT];
  logic [3:0]  ctrl_q [NSLOT];
  logic        overrun_q;
  logic        aborted_q;
  logic        vsync_q;

  // Engine state and working copies of the channel in progress.
  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [15:0]     wsrc_q, wsrc_d;
  logic [15:0]     wdst_q, wdst_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic            wsinc_q, wsinc_d;
  logic            wdinc_q, wdinc_d;
  logic            wone_q, wone_d;
  logic [7:0]      hold_q, hold_d;
  logic            abort_q, abort_d;

  // Registered bus-facing outputs.
  logic [15:0] m_addr_q, m_addr_d;
  logic [7:0]  m_do_q, m_do_d;
  logic        m_rw_q, m_rw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Decoded strobes.
  logic            rise_s;
  logic            abort_now_s;
  logic            clr_en_s;
  logic            set_abort_s;
  logic            end_pass_s;
  logic [CIW-1:0]  ch_idx_s;
  logic [RA-1:0]   sel_ch_s;
  logic [CIW-1:0]  sel_idx_s;
  logic            sel_valid_s;
  logic            wr_s;
  logic            w1c_s;

  assign rise_s      = vsync & ~vsync_q;
  assign abort_now_s = abort_q | ~vsync;
  assign ch_idx_s    = ch_q[CIW-1:0];
  assign sel_ch_s    = addr >> 3;
  assign sel_idx_s   = sel_ch_s[CIW-1:0];
  assign sel_valid_s = (sel_ch_s < RA'(CHANNELS));
  assign wr_s        = cs & rw & sel_valid_s;
  assign w1c_s       = wr_s & (addr[2:0] == 3'd7);

  assign m_addr = m_addr_q;
  assign m_do   = m_do_q;
  assign m_rw   = m_rw_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Configuration registers; a same-cycle CTRL write overrides the ONESHOT enable clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        src_q[i]  <= 16'h0000;
        dst_q[i]  <= 16'h0000;
        len_q[i]  <= 8'h00;
        ctrl_q[i] <= 4'h0;
      end
    end else begin
      if (clr_en_s) begin
        ctrl_q[ch_idx_s][0] <= 1'b0;
      end
      if (wr_s) begin
        case (addr[2:0])
          3'd0:    src_q[sel_idx_s][7:0]  <= di;
          3'd1:    src_q[sel_idx_s][15:8] <= di;
          3'd2:    dst_q[sel_idx_s][7:0]  <= di;
          3'd3:    dst_q[sel_idx_s][15:8] <= di;
          3'd4:    len_q[sel_idx_s]       <= di;
          3'd5:    ctrl_q[sel_idx_s]      <= di[3:0];
          default: ;
        endcase
      end
    end
  end

  // Sticky status flags; a hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (rise_s && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (w1c_s && di[1]) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end
      if (set_abort_s) begin
        aborted_q <= 1'b1;
      end else if (w1c_s && di[2]) begin
        aborted_q <= 1'b0;
      end else begin
        aborted_q <= aborted_q;
      end
    end
  end

  // State register with working copies and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vsync_q  <= 1'b0;
      ch_q     <= '0;
      wsrc_q   <= 16'h0000;
      wdst_q   <= 16'h0000;
      wcnt_q   <= 8'h00;
      wsinc_q  <= 1'b0;
      wdinc_q  <= 1'b0;
      wone_q   <= 1'b0;
      hold_q   <= 8'h00;
      abort_q  <= 1'b0;
      m_addr_q <= 16'h0000;
      m_do_q   <= 8'h00;
      m_rw_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync;
      ch_q     <= ch_d;
      wsrc_q   <= wsrc_d;
      wdst_q   <= wdst_d;
      wcnt_q   <= wcnt_d;
      wsinc_q  <= wsinc_d;
      wdinc_q  <= wdinc_d;
      wone_q   <= wone_d;
      hold_q   <= hold_d;
      abort_q  <= abort_d;
      m_addr_q <= m_addr_d;
      m_do_q   <= m_do_d;
      m_rw_q   <= m_rw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and working-copy update: channel walk, byte sequencing and abort handling.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wsrc_d      = wsrc_q;
    wdst_d      = wdst_q;
    wcnt_d      = wcnt_q;
    wsinc_d     = wsinc_q;
    wdinc_d     = wdinc_q;
    wone_d      = wone_q;
    hold_d      = hold_q;
    abort_d     = abort_q;
    clr_en_s    = 1'b0;
    set_abort_s = 1'b0;
    end_pass_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (rise_s) begin
          state_d = S_SCAN;
          ch_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        abort_d = abort_now_s;
        if (abort_now_s) begin
          state_d     = S_IDLE;
          abort_d     = 1'b0;
          set_abort_s = 1'b1;
          end_pass_s  = 1'b1;
        end else if (ch_q == CH_END) begin
          state_d    = S_IDLE;
          end_pass_s = 1'b1;
        end else if (ctrl_q[ch_idx_s][0] && (len_q[ch_idx_s] != 8'd0)) begin
          state_d = S_RD;
          wsrc_d  = src_q[ch_idx_s];
          wdst_d  = dst_q[ch_idx_s];
          wcnt_d  = len_q[ch_idx_s];
          wsinc_d = ctrl_q[ch_idx_s][1];
          wdinc_d = ctrl_q[ch_idx_s][2];
          wone_d  = ctrl_q[ch_idx_s][3];
        end else begin
          ch_d = ch_q + CHW'(1);
        end
      end
      S_RD: begin
        abort_d = abort_now_s;
        state_d = S_CAP;
      end
      S_CAP: begin
        abort_d = abort_now_s;
        hold_d  = m_di;
        state_d = S_WR;
      end
      S_WR: begin
        abort_d = abort_now_s;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        abort_d = abort_now_s;
        if (abort_now_s) begin
          state_d     = S_IDLE;
          abort_d     = 1'b0;
          set_abort_s = 1'b1;
          end_pass_s  = 1'b1;
        end else begin
          wsrc_d = wsinc_q ? (wsrc_q + 16'd1) : wsrc_q;
          wdst_d = wdinc_q ? (wdst_q + 16'd1) : wdst_q;
          wcnt_d = wcnt_q - 8'd1;
          if (wcnt_q == 8'd1) begin
            clr_en_s = wone_q;
            ch_d     = ch_q + CHW'(1);
            state_d  = S_SCAN;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so bus signals are valid throughout each state.
  always_comb begin
    m_addr_d = m_addr_q;
    m_do_d   = m_do_q;
    m_rw_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = end_pass_s;
    case (state_d)
      S_RD: begin
        m_addr_d = wsrc_d;
      end
      S_WR: begin
        m_addr_d = wdst_q;
        m_do_d   = hold_d;
        m_rw_d   = 1'b1;
      end
      default: begin
        m_addr_d = m_addr_q;
      end
    endcase
  end

  // Slave read mux; invalid channels and non-read cycles return 0.
  always_comb begin
    dout = 8'h00;
    if (cs && !rw && sel_valid_s) begin
      case (addr[2:0])
        3'd0:    dout = src_q[sel_idx_s][7:0];
        3'd1:    dout = src_q[sel_idx_s][15:8];
        3'd2:    dout = dst_q[sel_idx_s][7:0];
        3'd3:    dout = dst_q[sel_idx_s][15:8];
        3'd4:    dout = len_q[sel_idx_s];
        3'd5:    dout = {4'h0, ctrl_q[sel_idx_s]};
        3'd7:    dout = {5'b00000, aborted_q, overrun_q, busy_q};
        default: dout = 8'h00;
      endcase
    end else begin
      dout = 8'h00;
    end
  end

endmodule

// File: tb/tb_vblank_dma.sv
// tb_vblank_dma: directed and randomized frame passes checked against a
// transaction-level model of the copy engine (expected write list and timing).
module tb_vblank_dma;

  localparam int CH = 4;
  localparam int RA = 5;
  localparam int NO = 100000;

  logic          clk = 1'b0;
  logic          reset, vsync, cs, rw;
  logic [RA-1:0] addr;
  logic [7:0]    di, dout, m_do, m_di;
  logic [15:0]   m_addr;
  logic          m_rw, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit [7:0] mem [65536];
  bit [7:0] ref_mem [65536];
  int hist [256];

  int m_src [CH];
  int m_dst [CH];
  int m_len [CH];
  int m_ctrl [CH];

  int ew_rel[$], ew_addr[$], ew_data[$], ew_ra[$];
  int ow_rel[$], ow_addr[$], ow_data[$], ow_ra[$];
  int exp_busy, exp_done, exp_ab;
  int last_busy, last_done;

  vblank_dma #(.CHANNELS(CH), .RA(RA)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .cs(cs), .rw(rw), .addr(addr),
    .di(di), .dout(dout), .m_addr(m_addr), .m_do(m_do), .m_di(m_di),
    .m_rw(m_rw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input int ch, input int r, input int d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; addr = RA'(ch * 8 + r); di = 8'(d);
    @(negedge clk);
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic reg_rd(input int ch, input int r, output int d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; addr = RA'(ch * 8 + r);
    #1 d = int'(dout);
    cs = 1'b0;
  endtask

  task automatic prog(input int ch, input int src, input int dst, input int len, input int ctrl);
    reg_wr(ch, 0, src & 255);
    reg_wr(ch, 1, (src >> 8) & 255);
    reg_wr(ch, 2, dst & 255);
    reg_wr(ch, 3, (dst >> 8) & 255);
    reg_wr(ch, 4, len);
    reg_wr(ch, 5, ctrl);
    m_src[ch] = src & 16'hFFFF;
    m_dst[ch] = dst & 16'hFFFF;
    m_len[ch] = len & 8'hFF;
    m_ctrl[ch] = ctrl & 4'hF;
  endtask

  task automatic preload(input int a, input int d);
    mem[a & 16'hFFFF] = 8'(d);
    ref_mem[a & 16'hFFFF] = 8'(d);
  endtask

  // Reference: sequential copy semantics plus the per-step cycle costs of a pass.
  task automatic model_pass(input int drop_at);
    int t, ra, wa;
    bit ab;
    ew_rel.delete(); ew_addr.delete(); ew_data.delete(); ew_ra.delete();
    t = 1; ab = 1'b0;
    for (int ch = 0; ch < CH && !ab; ch++) begin
      if (drop_at <= t) begin
        ab = 1'b1;
      end else if ((m_ctrl[ch] & 1) != 0 && m_len[ch] != 0) begin
        t++;
        for (int k = 0; k < m_len[ch] && !ab; k++) begin
          ra = (m_src[ch] + (((m_ctrl[ch] >> 1) & 1) != 0 ? k : 0)) & 16'hFFFF;
          wa = (m_dst[ch] + (((m_ctrl[ch] >> 2) & 1) != 0 ? k : 0)) & 16'hFFFF;
          ew_rel.push_back(t + 2); ew_addr.push_back(wa);
          ew_data.push_back(int'(ref_mem[ra])); ew_ra.push_back(ra);
          ref_mem[wa] = ref_mem[ra];
          if (drop_at <= t + 3) begin
            ab = 1'b1;
            t = t + 3;
          end else begin
            t = t + 4;
          end
        end
        if (!ab && ((m_ctrl[ch] >> 3) & 1) != 0) m_ctrl[ch] = m_ctrl[ch] & 14;
      end else begin
        t++;
      end
    end
    if (!ab && drop_at <= t) ab = 1'b1;
    exp_busy = t;
    exp_done = t + 1;
    exp_ab = ab;
  endtask

  // Runs one frame pass, acting as the bus memory, and compares against the model.
  task automatic run_pass(input int drop_at, input int rerise_at, input int exp_ovr);
    int base, rel, busy_n, done_rel, st, exp_st;
    model_pass(drop_at);
    ow_rel.delete(); ow_addr.delete(); ow_data.delete(); ow_ra.delete();
    @(negedge clk);
    vsync = 1'b1;
    base = cyc;
    busy_n = 0; done_rel = -1;
    for (int k = 0; k < 3000 && done_rel < 0; k++) begin
      @(negedge clk);
      rel = cyc - base;
      if (rel == drop_at) vsync = 1'b0;
      if (rel == rerise_at) vsync = 1'b1;
      m_di = mem[m_addr];
      hist[rel & 255] = int'(m_addr);
      if (busy) busy_n++;
      if (m_rw) begin
        ow_rel.push_back(rel); ow_addr.push_back(int'(m_addr));
        ow_data.push_back(int'(m_do)); ow_ra.push_back(hist[(rel - 2) & 255]);
        mem[m_addr] = m_do;
      end
      if (done) done_rel = rel;
    end
    check("busy_cycles", busy_n, exp_busy);
    check("done_cycle", done_rel, exp_done);
    check("write_count", ow_rel.size(), ew_rel.size());
    for (int i = 0; i < ew_rel.size() && i < ow_rel.size(); i++) begin
      check("wr_cycle", ow_rel[i], ew_rel[i]);
      check("wr_addr", ow_addr[i], ew_addr[i]);
      check("wr_data", ow_data[i], ew_data[i]);
      check("rd_addr", ow_ra[i], ew_ra[i]);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    vsync = 1'b0;
    last_busy = busy_n;
    last_done = done_rel;
    exp_st = (exp_ab != 0 ? 4 : 0) | (exp_ovr != 0 ? 2 : 0);
    reg_rd(0, 7, st);
    check("status", st, exp_st);
    reg_wr(1, 7, exp_st);
    reg_rd(CH - 1, 7, st);
    check("status_w1c", st, 0);
  endtask

  task automatic clear_all();
    for (int c = 0; c < CH; c++) prog(c, 0, 0, 0, 0);
  endtask

  initial begin
    int d;
    reset = 1'b1; vsync = 1'b0; cs = 1'b0; rw = 1'b0; addr = '0; di = 8'h00; m_di = 8'h00;
    for (int c = 0; c < CH; c++) begin
      m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_ctrl[c] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_m_rw", m_rw, 1'b0);
    check("rst_m_addr", m_addr, 16'h0000);
    check("rst_done", done, 1'b0);
    reg_rd(0, 7, d); check("rst_status", d, 0);
    reg_rd(2, 5, d); check("rst_ctrl", d, 0);

    // Single channel, incrementing copy
    prog(0, 16'h0010, 16'hF003, 3, 8'h07);
    preload(16'h0010, 8'hAA); preload(16'h0011, 8'hBB); preload(16'h0012, 8'hCC);
    run_pass(NO, NO, 0);
    check("t1_busy", last_busy, 17);
    if (ow_data.size() == 3) begin
      check("t1_d0", ow_data[0], 8'hAA);
      check("t1_a2", ow_addr[2], 16'hF005);
      check("t1_d2", ow_data[2], 8'hCC);
    end

    // Fixed destination plus a ONESHOT channel
    clear_all();
    prog(0, 16'h0040, 16'hEFF8, 2, 8'h03);
    prog(2, 16'h0050, 16'h0060, 1, 8'h0F);
    preload(16'h0040, 8'h11); preload(16'h0041, 8'h22); preload(16'h0050, 8'h33);
    run_pass(NO, NO, 0);
    if (ow_addr.size() == 3) begin
      check("t2_a0", ow_addr[0], 16'hEFF8);
      check("t2_a1", ow_addr[1], 16'hEFF8);
    end
    reg_rd(2, 5, d); check("t2_ctrl2", d, 8'h0E);
    reg_rd(0, 5, d); check("t2_ctrl0", d, 8'h03);

    // Source address wrap
    clear_all();
    prog(0, 16'hFFFF, 16'h3000, 2, 8'h07);
    preload(16'hFFFF, 8'h5A); preload(16'h0000, 8'hA5);
    run_pass(NO, NO, 0);
    if (ow_ra.size() == 2) begin
      check("t3_ra0", ow_ra[0], 16'hFFFF);
      check("t3_ra1", ow_ra[1], 16'h0000);
    end

    // Nothing enabled (EN=0 on one, LEN=0 on another)
    clear_all();
    prog(1, 16'h0100, 16'h0200, 4, 8'h00);
    prog(3, 16'h0100, 16'h0200, 0, 8'h07);
    run_pass(NO, NO, 0);
    check("t5_done", last_done, CH + 2);

    // Abort during the second byte, then abort with a vsync re-rise
    clear_all();
    prog(0, 16'h0300, 16'h0400, 5, 8'h07);
    for (int k = 0; k < 5; k++) preload(16'h0300 + k, 8'h70 + k);
    run_pass(6, NO, 0);
    check("t4_writes", ow_rel.size(), 2);
    run_pass(6, 7, 1);

    // Reset while the first byte is in CAP
    clear_all();
    prog(0, 16'h0500, 16'h0600, 3, 8'h07);
    @(negedge clk); vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; vsync = 1'b0;
    @(negedge clk);
    check("rst_cap_m_rw", m_rw, 1'b0);
    check("rst_cap_busy", busy, 1'b0);
    check("rst_cap_m_addr", m_addr, 16'h0000);
    reset = 1'b0;
    reg_rd(0, 0, d); check("rst_cap_src", d, 0);
    reg_rd(0, 4, d); check("rst_cap_len", d, 0);
    reg_rd(0, 5, d); check("rst_cap_ctrl", d, 0);
    for (int c = 0; c < CH; c++) begin
      m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_ctrl[c] = 0;
    end
    run_pass(NO, NO, 0);
    check("rst_cap_nowr", ow_rel.size(), 0);

    // Randomized configurations, some with an early vsync drop
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < CH; c++) begin
        int s, ln;
        s = $urandom_range(0, 65535);
        ln = $urandom_range(0, 5);
        prog(c, s, $urandom_range(0, 65535), ln, $urandom_range(0, 15));
        for (int k = 0; k < ln; k++) preload(s + k, $urandom_range(0, 255));
      end
      run_pass((p % 3 == 2) ? $urandom_range(1, 30) : NO, NO, 0);
      for (int c = 0; c < CH; c++) begin
        reg_rd(c, 5, d); check("rnd_ctrl", d, m_ctrl[c]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vblank_dma.md
Name: vblank_dma

Overview:
- Parametrised successor to the hard-wired vsync control sequencer: a multi-channel, register-programmed block-copy engine.
- On each vsync rising edge it walks channels 0..CHANNELS-1 in order and copies LEN bytes per enabled channel from source to destination over the shared 16-bit address / 8-bit data bus, using the codebase rw convention (1=write, 0=read).
- The top level muxes this master onto the bus while busy=1.
- Configured through a peripheral-style cs/rw/addr/di/dout slave port.

Parameters:
CHANNELS, 4, number of channels (1..8)
RA, $clog2(CHANNELS)+3, slave register address width (8 registers per channel)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  frame-blank level; rising edge starts a frame pass
cs  in  1  slave chip select
rw  in  1  slave direction, 1=write, 0=read
addr  in  RA  slave register address: channel=addr[RA-1:3], reg=addr[2:0]
di  in  8  slave write data
dout  out  8  slave read data, combinational from cs/addr
m_addr  out  16  master bus address
m_do  out  8  master write data
m_di  in  8  master read data, valid the cycle after m_addr is presented with m_rw=0
m_rw  out  1  master direction, 1=write
busy  out  1  1 while the engine owns the bus
done  out  1  one-cycle pulse when a frame pass ends (normally or aborted)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state updates on posedge clk.
- Reset: all registers 0; state IDLE; m_addr=0, m_do=0, m_rw=0, busy=0, done=0, dout=0; vsync edge detector history=0.
- Per-channel registers (reg index):
  - 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN (0 = skip channel).
  - 5 CTRL: bit0 EN, bit1 SRC_INC, bit2 DST_INC, bit3 ONESHOT; bits 7:4 read 0.
  - 6 reads 0, writes ignored.
  - 7 STATUS (global, mirrored in every channel): bit0 busy (RO), bit1 OVERRUN, bit2 ABORTED; write 1 clears bits 1/2.
- Slave access:
  - A write happens when cs&rw at the clock edge.
  - dout = selected register when cs&~rw, else 0.
  - Channel index >= CHANNELS reads 0 and ignores writes.
- States: IDLE, SCAN, RD, CAP, WR, NEXT.
  - IDLE: on vsync rising edge (vsync=1, previous sample=0): ch=0, busy=1, go to SCAN.
  - SCAN:
    - If ch==CHANNELS: go IDLE, busy=0, pulse done.
    - Else if EN[ch] && LEN[ch]!=0: load working src/dst/count from the channel registers, go RD.
    - Else ch++ and stay in SCAN. Each skipped channel costs one cycle.
  - RD: m_addr=src, m_rw=0.
  - CAP: latch m_di into a holding register.
  - WR: m_addr=dst, m_do=held byte, m_rw=1.
  - NEXT:
    - m_rw=0.
    - If SRC_INC, src+1; if DST_INC, dst+1. Both wrap modulo 2^16.
    - count-1.
    - If count reaches 0: clear EN[ch] if ONESHOT; ch++; go SCAN. Otherwise go RD.
  - Cost is 4 cycles per byte.
- Working copies: mid-channel register writes do not affect the channel in progress. They take effect the next time the channel is loaded.
- vsync falls while busy: finish the current byte through WR, then go IDLE, busy=0, set ABORTED, pulse done. Remaining channels are not processed.
- vsync rising edge while busy (only possible after an abort re-rise): ignored, OVERRUN set.
- Simultaneous events:
  - Slave write to CTRL in the same cycle as a ONESHOT clear: the slave write wins.
  - W1C on STATUS in the same cycle as a hardware set: the set wins.
- m_rw is 1 only in WR. When busy=0: m_rw=0 and m_addr holds its last value.
- reset mid-transfer: immediate return to reset values. A partially completed channel is not resumed.

Test Plan:
- Ch0 SRC=0x0010, DST=0xF003, LEN=3, CTRL=0x07; RAM[0x10..0x12]=AA,BB,CC; vsync rise -> writes AA,BB,CC to F003..F005 at 4-cycle spacing; done pulses; busy high for 1+12+4 cycles.
- Ch0 CTRL=0x03 (DST_INC=0), DST=0xEFF8, LEN=2; ch2 CTRL=0x0F, LEN=1 -> ch0 writes EFF8 twice; ch2 then runs; after the pass ch2 CTRL reads 0x0E and ch0 CTRL still reads 0x03.
- SRC=0xFFFF, SRC_INC, LEN=2 -> read addresses FFFF then 0000.
- vsync dropped during byte 2 of a LEN=5 channel -> byte 2 is written, no further RD; STATUS=0x04; writing 0x04 to STATUS clears it to 0.
- LEN=0 or EN=0 on all channels -> no bus writes; done is asserted CHANNELS+2 cycles after the vsync rise.
- Assert reset during CAP -> next cycle m_rw=0, busy=0, all registers 0; a new vsync with nothing programmed performs no transfers.
